// File: rtl/mvm_pkg.sv
// Shared types and default sizing for the matrix x vector sequencer.
package mvm_pkg;

    localparam int N_DEF         = 3;
    localparam int LOGSIZE_M_DEF = 4;
    localparam int LOGSIZE_X_DEF = 2;

    typedef enum logic [1:0] {
        LOAD_M,
        LOAD_X,
        COMPUTE,
        OUT
    } state_t;

endpackage

// File: rtl/mvm_if.sv
// Handshake and datapath-control bundle between mvm_ctrl and its surroundings.
// master: the controller. slave: upstream source, downstream sink and datapath.
interface mvm_if
    import mvm_pkg::*;
#(
    parameter int LOGSIZE_M = LOGSIZE_M_DEF,
    parameter int LOGSIZE_X = LOGSIZE_X_DEF
) ();

    logic                 s_valid;
    logic                 s_ready;
    logic                 wr_en_M;
    logic                 wr_en_X;
    logic [LOGSIZE_M-1:0] addr_M;
    logic [LOGSIZE_X-1:0] addr_X;
    logic                 clr_acc;
    logic                 mac_en;
    logic                 m_valid;
    logic                 m_ready;
    logic [LOGSIZE_X-1:0] row_idx;
    logic                 m_last;

    modport master (
        input  s_valid, m_ready,
        output s_ready, wr_en_M, wr_en_X, addr_M, addr_X,
               clr_acc, mac_en, m_valid, row_idx, m_last
    );

    modport slave (
        output s_valid, m_ready,
        input  s_ready, wr_en_M, wr_en_X, addr_M, addr_X,
               clr_acc, mac_en, m_valid, row_idx, m_last
    );

endinterface

// File: rtl/mvm_addr_gen.sv
// Row / phase counters for the compute pass. The matrix read address is a
// running row base plus the phase, so no multiplier is needed.
module mvm_addr_gen
    import mvm_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int LOGSIZE_M = LOGSIZE_M_DEF,
    parameter int LOGSIZE_X = LOGSIZE_X_DEF,
    parameter int K_W       = $clog2(N + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 k_inc,
    input  logic                 row_inc,
    output logic [LOGSIZE_X-1:0] row,
    output logic [K_W-1:0]       k,
    output logic [LOGSIZE_M-1:0] addr
);

    logic [LOGSIZE_M-1:0] base;

    // Counter update: clear wins, then row advance (restarts phase), then phase step.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row  <= '0;
            k    <= '0;
            base <= '0;
        end else if (clear) begin
            row  <= '0;
            k    <= '0;
            base <= '0;
        end else if (row_inc) begin
            row  <= row + LOGSIZE_X'(1);
            base <= base + LOGSIZE_M'(N);
            k    <= '0;
        end else if (k_inc) begin
            k    <= k + K_W'(1);
        end
    end

    assign addr = base + LOGSIZE_M'(k);

endmodule

// File: rtl/mvm_ctrl.sv
// Sequencer that turns the 8-bit MAC datapath into an N x N matrix times
// N-vector engine: loads M then X, runs one dot product per row, and hands
// each row result to a valid/ready sink.
module mvm_ctrl
    import mvm_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int LOGSIZE_M = LOGSIZE_M_DEF,
    parameter int LOGSIZE_X = LOGSIZE_X_DEF
) (
    input logic   clk,
    input logic   reset,
    mvm_if.master bus
);

    localparam int K_W = $clog2(N + 1);

    state_t               state;
    logic [LOGSIZE_M-1:0] wcnt;
    logic                 s_ready_q;
    logic                 clr_acc_q;
    logic                 mac_en_q;
    logic                 m_valid_q;
    logic                 m_last_q;

    logic [LOGSIZE_X-1:0] row;
    logic [K_W-1:0]       k;
    logic [LOGSIZE_M-1:0] comp_addr;

    logic accept;
    logic row_last;
    logic k_done;
    logic ag_clear;
    logic ag_k_inc;
    logic ag_row_inc;

    assign accept   = bus.s_valid && s_ready_q;
    assign row_last = (row == LOGSIZE_X'(N - 1));
    assign k_done   = (k == K_W'(N));

    mvm_addr_gen #(
        .N         (N),
        .LOGSIZE_M (LOGSIZE_M),
        .LOGSIZE_X (LOGSIZE_X),
        .K_W       (K_W)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (ag_clear),
        .k_inc   (ag_k_inc),
        .row_inc (ag_row_inc),
        .row     (row),
        .k       (k),
        .addr    (comp_addr)
    );

    // Counter commands: held at zero while loading, step the phase during
    // COMPUTE, advance or restart the row on each accepted result.
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        ag_clear   = 1'b0;
        ag_k_inc   = 1'b0;
        ag_row_inc = 1'b0;
        unique case (state)
            LOAD_M, LOAD_X: ag_clear = 1'b1;
            COMPUTE:        ag_k_inc = !k_done;
            OUT: begin
                if (bus.m_ready) begin
                    ag_clear   = row_last;
                    ag_row_inc = !row_last;
                end
            end
            default: ag_clear = 1'b1;
        endcase
    end

    // Main sequencer: state, load word counter and the registered control outputs,
    // which are set one cycle ahead so they line up with the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= LOAD_M;
            wcnt      <= '0;
            s_ready_q <= 1'b1;
            clr_acc_q <= 1'b0;
            mac_en_q  <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            unique case (state)
                LOAD_M: begin
                    if (accept) begin
                        if (wcnt == LOGSIZE_M'(N * N - 1)) begin
                            state <= LOAD_X;
                            wcnt  <= '0;
                        end else begin
                            wcnt <= wcnt + LOGSIZE_M'(1);
                        end
                    end
                end
                LOAD_X: begin
                    if (accept) begin
                        if (wcnt == LOGSIZE_M'(N - 1)) begin
                            state     <= COMPUTE;
                            wcnt      <= '0;
                            s_ready_q <= 1'b0;
                            clr_acc_q <= 1'b1;
                        end else begin
                            wcnt <= wcnt + LOGSIZE_M'(1);
                        end
                    end
                end
                COMPUTE: begin
                    clr_acc_q <= 1'b0;
                    if (k_done) begin
                        state     <= OUT;
                        mac_en_q  <= 1'b0;
                        m_valid_q <= 1'b1;
                        m_last_q  <= row_last;
                    end else begin
                        mac_en_q <= 1'b1;
                    end
                end
                OUT: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        m_last_q  <= 1'b0;
                        if (row_last) begin
                            state     <= LOAD_M;
                            s_ready_q <= 1'b1;
                        end else begin
                            state     <= COMPUTE;
                            clr_acc_q <= 1'b1;
                        end
                    end
                end
                default: state <= LOAD_M;
            endcase
        end
    end

    // Address steering: write counter while loading, row base + phase otherwise.
    always_comb begin
        bus.addr_M = '0;
        bus.addr_X = '0;
        unique case (state)
            LOAD_M: bus.addr_M = wcnt;
            LOAD_X: bus.addr_X = LOGSIZE_X'(wcnt);
            default: begin
                bus.addr_M = comp_addr;
                bus.addr_X = LOGSIZE_X'(k);
            end
        endcase
    end

    assign bus.s_ready = s_ready_q;
    assign bus.wr_en_M = accept && (state == LOAD_M);
    assign bus.wr_en_X = accept && (state == LOAD_X);
    assign bus.clr_acc = clr_acc_q;
    assign bus.mac_en  = mac_en_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_last  = m_last_q;
    assign bus.row_idx = row;

endmodule

// File: doc/mvm_ctrl.md
# mvm_ctrl

Sequencing controller for the 8-bit multiply-accumulate datapath, making the pair an N×N matrix × N-vector engine. It does four things:
- Accepts a stream of matrix words, then vector words, from an upstream valid/ready source and issues the datapath write strobes and addresses.
- Runs one dot product per row by driving read addresses, accumulator clear and MAC enable.
- Presents each 16-bit row result (datapath `data_out`) to a downstream valid/ready sink.
- Sits between the input stream and the datapath; the datapath's `data_in`/`data_out` buses bypass it.

## Interface
- `N`, 3, matrix dimension; matrix holds N*N words, vector holds N words.
- `LOGSIZE_M`, 4, width of `addr_M`; must satisfy 2^LOGSIZE_M ≥ N*N.
- `LOGSIZE_X`, 2, width of `addr_X`; must satisfy 2^LOGSIZE_X ≥ N.
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  upstream word valid.
- `s_ready`  out  1  controller can accept a word.
- `wr_en_M`  out  1  write strobe to datapath matrix memory.
- `wr_en_X`  out  1  write strobe to datapath vector memory.
- `addr_M`  out  LOGSIZE_M  matrix address (write or read).
- `addr_X`  out  LOGSIZE_X  vector address (write or read).
- `clr_acc`  out  1  accumulator clear to datapath.
- `mac_en`  out  1  MAC enable, drives the datapath `m_ready` input.
- `m_valid`  out  1  row result valid on datapath `data_out`.
- `m_ready`  in  1  downstream accepts result.
- `row_idx`  out  LOGSIZE_X  row index of the current result.
- `m_last`  out  1  asserted with `m_valid` for the final row (row N-1).

## Operation
- States:
  - `LOAD_M`: `s_ready`=1. Each accepted word (s_valid&&s_ready) produces `wr_en_M`=1 combinationally at `addr_M`=wcnt; wcnt increments. After word N*N-1 is accepted, go to `LOAD_X`, wcnt=0.
  - `LOAD_X`: same handshake with `wr_en_X` and `addr_X`=wcnt. After word N-1, go to `COMPUTE`, row=0, k=0.
  - `COMPUTE`: phase counter k=0..N. For k<N, drive `addr_M`=row*N+k and `addr_X`=k.
    - k=0: `clr_acc`=1, `mac_en`=0.
    - k=1..N: `mac_en`=1.
    - After k=N, go to `OUT`.
  - `OUT`: `m_valid`=1; all strobes 0; addresses hold. On m_valid&&m_ready:
    - if row<N-1, row++ and go to `COMPUTE` (k=0);
    - else go to `LOAD_M` (new problem; previous contents are overwritten).
- `s_ready`=0 outside the load states; `s_valid` is ignored there, and no write strobe may ever assert outside its load state.
- Strobes are mutually exclusive. `wr_en_*`, `clr_acc` and `mac_en` are never high together.
- Arithmetic is performed by the datapath: 8×8 products, 16-bit accumulation wrapping modulo 2^16.

## Timing
- Reset (async assert, sync deassert): state=`LOAD_M`, wcnt=row=k=0.
  - Outputs at reset: `s_ready`=1, `wr_en_M`=`wr_en_X`=`clr_acc`=`mac_en`=`m_valid`=`m_last`=0, addresses=0, `row_idx`=0.
  - Reset mid-operation aborts immediately; partial loads are discarded.
- Read pipeline alignment:
  - Address k is issued in COMPUTE cycle k; the registered read is valid in cycle k+1, where `mac_en` accumulates it.
  - `clr_acc` in cycle 0 zeroes the accumulator for cycle 1.
- Latency:
  - First `m_valid` appears N+1 cycles after entering `COMPUTE`, i.e. N+2 cycles after the last vector word is accepted.
  - Row-to-row minimum is N+2 cycles when `m_ready` is held high.
- In `OUT`, `mac_en`=0, so the datapath holds the final sum. `data_out` must be stable for every cycle `m_valid` is high.
- Gaps in `s_valid` stall the counters; there is no timeout.

## Structure
- Package `mvm_pkg`: state enum (`LOAD_M`, `LOAD_X`, `COMPUTE`, `OUT`), default N and address widths.
- Sub-module `mvm_addr_gen`: holds the row/k counters and computes row*N+k (adder, no multiplier, by keeping a running row base).
- The FSM stays in `mvm_ctrl`.
- The bench instantiates `mvm_ctrl` together with the MAC datapath.

## Test plan
- **Basic:** load M=1..9 and X={1,2,3}, `m_ready` tied high → results 14, 32, 50 with `row_idx` 0, 1, 2. `m_last` is high only with 50. First `m_valid` appears 5 cycles after the last X accept.
- **Backpressure:** hold `m_ready` low for 4 cycles on row 1 → `m_valid` and `data_out`=32 stay stable, with no strobes. Row 2 is not started until the handshake.
- **Input bubbles:** toggle `s_valid` every other cycle during the load → same results as Basic. `wr_en_*` is asserted only on accepted words.
- **Overflow:** all words 255 → each row result is 195075 mod 65536 = 64003.
- **Reset mid-operation:** drive `reset` low in COMPUTE cycle k=1 of row 1 → outputs return to reset values asynchronously and the state is `LOAD_M`. A reload with Basic data then gives 14, 32, 50.
- **Back-to-back problems:** second load with X={0,0,1} immediately after row 2 is accepted → results 3, 6, 9. `s_valid` pulses during `OUT` produce no writes.
